// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares one single-port RAM command channel between two
// requesters (port 0 = SPI slave word stream, port 1 = host/BIST port).
// Grants round-robin in IDLE, locks the RAM to the owner across an
// address+data pair, forwards each accepted word as a one-cycle strobe and
// routes the read response back to the port that issued the read.
module ram_cmd_arbiter #(
  parameter int LOCK_TIMEOUT = 16,
  parameter int RD_TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_data,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [9:0] req1_data,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       owner,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RCW = $clog2(RD_TIMEOUT + 1);

  // The last idle cycle allowed: the timeout fires when this cycle also
  // passes without the awaited event.
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_TIMEOUT - 1);
  localparam logic [RCW-1:0] RD_LAST   = RCW'(RD_TIMEOUT - 1);
  localparam logic [LCW-1:0] LOCK_MAX  = '1;
  localparam logic [RCW-1:0] RD_MAX    = '1;

  state_t         state, state_next;
  logic [LCW-1:0] lock_cnt, lock_cnt_next;
  logic [RCW-1:0] rd_cnt, rd_cnt_next;
  logic           last_owner;
  logic           err_next;
  logic           rsp_fire;

  logic           sel0, sel1;
  logic           hs0, hs1, hs;
  logic [9:0]     hs_word;
  logic [1:0]     hs_op;

  // Round-robin pick: a lone valid port wins; on a tie the port that was
  // not granted last time wins.
  assign sel0 = req0_valid && (!req1_valid || last_owner);
  assign sel1 = req1_valid && (!req0_valid || !last_owner);

  // NOTE: ready is purely combinational from valid and registered state, so
  // the requester sees acceptance in the same cycle it presents the word.
  assign req0_ready = ((state == IDLE) && sel0) || ((state == LOCKED) && !owner);
  assign req1_ready = ((state == IDLE) && sel1) || ((state == LOCKED) && owner);

  assign hs0     = req0_valid && req0_ready;
  assign hs1     = req1_valid && req1_ready;
  assign hs      = hs0 || hs1;
  assign hs_word = hs1 ? req1_data : req0_data;
  assign hs_op   = hs_word[9:8];

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, timeout counters, error and response-fire decisions.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next    = state;
    lock_cnt_next = lock_cnt;
    rd_cnt_next   = rd_cnt;
    err_next      = 1'b0;
    rsp_fire      = 1'b0;

    unique case (state)
      IDLE: begin
        lock_cnt_next = '0;
        rd_cnt_next   = '0;
        if (hs) begin
          unique case (hs_op)
            OP_WR_ADDR, OP_RD_ADDR: state_next = LOCKED;
            OP_RD_DATA:             state_next = WAIT_RD;
            default:                state_next = IDLE;  // write data: RAM reuses latched address
          endcase
        end
      end

      LOCKED: begin
        if (hs) begin
          // An owner handshake always beats a timeout landing in the same cycle.
          lock_cnt_next = '0;
          unique case (hs_op)
            OP_WR_ADDR, OP_RD_ADDR: state_next = LOCKED;
            OP_WR_DATA:             state_next = IDLE;
            default: begin
              state_next  = WAIT_RD;
              rd_cnt_next = '0;
            end
          endcase
        end else if (lock_cnt == LOCK_LAST) begin
          state_next    = IDLE;
          err_next      = 1'b1;
          lock_cnt_next = '0;
        end else if (lock_cnt != LOCK_MAX) begin
          lock_cnt_next = lock_cnt + LCW'(1);
        end
      end

      WAIT_RD: begin
        if (ram_tx_valid) begin
          // A response in the final allowed cycle still counts.
          rsp_fire    = 1'b1;
          state_next  = IDLE;
          rd_cnt_next = '0;
        end else if (rd_cnt == RD_LAST) begin
          state_next  = IDLE;
          err_next    = 1'b1;
          rd_cnt_next = '0;
        end else if (rd_cnt != RD_MAX) begin
          rd_cnt_next = rd_cnt + RCW'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
        rd_cnt_next   = '0;
      end
    endcase
  end

  // Registered datapath: counters, ownership, RAM strobe and responses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      lock_cnt     <= '0;
      rd_cnt       <= '0;
      last_owner   <= 1'b1;
      owner        <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      err_timeout  <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
    end else begin
      lock_cnt     <= lock_cnt_next;
      rd_cnt       <= rd_cnt_next;
      err_timeout  <= err_next;
      ram_rx_valid <= hs;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;

      if (hs) begin
        ram_din    <= hs_word;
        owner      <= hs1;
        last_owner <= hs1;
      end

      if (rsp_fire) begin
        if (owner) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= ram_dout;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= ram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: a vector table for single-port
// command sequences plus hand-written multi-cycle corner cases. Every RAM
// strobe and response is checked against queues filled when stimulus is driven.
module tb_ram_cmd_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       owner, busy, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] q_ram[$];
  logic [7:0] q_rsp0[$];
  logic [7:0] q_rsp1[$];

  typedef struct {
    bit         port;
    logic [9:0] word;
    bit         busy_after;
  } vec_t;

  vec_t vecs[8];

  ram_cmd_arbiter #(.LOCK_TIMEOUT(16), .RD_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_data    (rsp0_data),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_data    (rsp1_data),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .owner        (owner),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe/response the DUT emits must match the next
  // expected entry; a pulse with nothing expected is an error.
  always @(negedge clk) begin
    if (ram_rx_valid) begin
      if (q_ram.size() == 0) check("ram_unexpected_strobe", {22'd0, ram_din}, 32'h3ff);
      else check("ram_sb", {22'd0, ram_din}, {22'd0, q_ram.pop_front()});
    end
    if (rsp0_valid) begin
      if (q_rsp0.size() == 0) check("rsp0_unexpected", {31'd0, rsp0_valid}, 32'd0);
      else check("rsp0_sb", {24'd0, rsp0_data}, {24'd0, q_rsp0.pop_front()});
    end
    if (rsp1_valid) begin
      if (q_rsp1.size() == 0) check("rsp1_unexpected", {31'd0, rsp1_valid}, 32'd0);
      else check("rsp1_sb", {24'd0, rsp1_data}, {24'd0, q_rsp1.pop_front()});
    end
  end

  // Present one word on a port, wait (bounded) for ready, then check the
  // strobe, busy and owner in the following cycle. Returns one cycle after
  // the handshake with the port's valid dropped.
  task automatic send(input bit port, input logic [9:0] word, input bit exp_busy, input string name);
    int waited;
    if (port) begin req1_valid = 1'b1; req1_data = word; end
    else      begin req0_valid = 1'b1; req0_data = word; end
    #1;
    waited = 0;
    while (!(port ? req1_ready : req0_ready) && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_ready"}, {31'd0, (port ? req1_ready : req0_ready)}, 32'd1);
    q_ram.push_back(word);
    tick();
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    check({name, "_strobe"}, {31'd0, ram_rx_valid}, 32'd1);
    check({name, "_din"}, {22'd0, ram_din}, {22'd0, word});
    check({name, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check({name, "_owner"}, {31'd0, owner}, {31'd0, port});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ram_din"}, {22'd0, ram_din}, 32'd0);
    check({name, "_rx_valid"}, {31'd0, ram_rx_valid}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_owner"}, {31'd0, owner}, 32'd0);
    check({name, "_err"}, {31'd0, err_timeout}, 32'd0);
    check({name, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    check({name, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    check({name, "_rsp0_data"}, {24'd0, rsp0_data}, 32'd0);
    check({name, "_rsp1_data"}, {24'd0, rsp1_data}, 32'd0);
    check({name, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({name, "_ready1"}, {31'd0, req1_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{port: 1'b0, word: 10'h005, busy_after: 1'b1};  // write addr -> LOCKED
    vecs[1] = '{port: 1'b0, word: 10'h1A5, busy_after: 1'b0};  // write data -> IDLE
    vecs[2] = '{port: 1'b1, word: 10'h0AA, busy_after: 1'b1};
    vecs[3] = '{port: 1'b1, word: 10'h155, busy_after: 1'b0};
    vecs[4] = '{port: 1'b0, word: 10'h100, busy_after: 1'b0};  // bare write data stays IDLE
    vecs[5] = '{port: 1'b1, word: 10'h2C3, busy_after: 1'b1};  // read addr -> LOCKED
    vecs[6] = '{port: 1'b1, word: 10'h2C4, busy_after: 1'b1};  // re-address stays LOCKED
    vecs[7] = '{port: 1'b1, word: 10'h1FF, busy_after: 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    ram_tx_valid = 1'b0; ram_dout = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven single-port sequences.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].port, vecs[i].word, vecs[i].busy_after, $sformatf("vec%0d", i));
    end

    // Both ports valid out of reset: port 0 first, port 1 after the unlock.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 10'h011;
    req1_valid = 1'b1; req1_data = 10'h022;
    #1;
    check("tie_first_ready0", {31'd0, req0_ready}, 32'd1);
    check("tie_first_ready1", {31'd0, req1_ready}, 32'd0);
    q_ram.push_back(10'h011);
    tick();
    req0_data = 10'h1AB;
    #1;
    check("tie_locked_ready0", {31'd0, req0_ready}, 32'd1);
    check("tie_locked_ready1", {31'd0, req1_ready}, 32'd0);
    q_ram.push_back(10'h1AB);
    tick();
    req0_data = 10'h0CC;
    #1;
    check("tie_second_ready1", {31'd0, req1_ready}, 32'd1);
    check("tie_second_ready0", {31'd0, req0_ready}, 32'd0);
    q_ram.push_back(10'h022);
    tick();
    req0_valid = 1'b0;
    req1_data = 10'h100;
    #1;
    check("tie_p1_owner", {31'd0, owner}, 32'd1);
    check("tie_p1_locked_ready1", {31'd0, req1_ready}, 32'd1);
    q_ram.push_back(10'h100);
    tick();
    req1_valid = 1'b0;
    check("tie_done_busy", {31'd0, busy}, 32'd0);

    // Port 1 read: address, read-data command, RAM answers one cycle after the strobe.
    send(1'b1, 10'h203, 1'b1, "rd_addr");
    req1_valid = 1'b1; req1_data = 10'h300;
    #1;
    check("rd_cmd_ready", {31'd0, req1_ready}, 32'd1);
    q_ram.push_back(10'h300);
    tick();
    req1_valid = 1'b0;
    check("rd_wait_busy", {31'd0, busy}, 32'd1);
    check("rd_wait_strobe", {31'd0, ram_rx_valid}, 32'd1);
    req0_valid = 1'b1; req0_data = 10'h000;
    req1_valid = 1'b1; req1_data = 10'h000;
    #1;
    check("rd_wait_ready0", {31'd0, req0_ready}, 32'd0);
    check("rd_wait_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ram_tx_valid = 1'b1; ram_dout = 8'h3C;
    q_rsp1.push_back(8'h3C);
    tick();
    ram_tx_valid = 1'b0;
    check("rd_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("rd_rsp1_data", {24'd0, rsp1_data}, 32'h3C);
    check("rd_rsp0_quiet", {31'd0, rsp0_valid}, 32'd0);
    check("rd_done_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rd_rsp1_single", {31'd0, rsp1_valid}, 32'd0);
    check("rd_rsp1_hold", {24'd0, rsp1_data}, 32'h3C);

    // Stray RAM data outside WAIT_RD is ignored.
    ram_tx_valid = 1'b1; ram_dout = 8'h99;
    tick();
    ram_tx_valid = 1'b0;
    check("stray_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check("stray_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check("stray_hold", {24'd0, rsp1_data}, 32'h3C);

    // Lock timeout: port 0 goes silent, port 1 waits and is accepted right after.
    req0_valid = 1'b1; req0_data = 10'h207;
    #1;
    check("lto_ready0", {31'd0, req0_ready}, 32'd1);
    q_ram.push_back(10'h207);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 10'h0EE;
    #1;
    check("lto_blocked_ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("lto_quiet%0d", i), {31'd0, err_timeout}, 32'd0);
      tick();
    end
    check("lto_err", {31'd0, err_timeout}, 32'd1);
    check("lto_idle", {31'd0, busy}, 32'd0);
    check("lto_next_ready1", {31'd0, req1_ready}, 32'd1);
    q_ram.push_back(10'h0EE);
    tick();
    req1_valid = 1'b0;
    check("lto_err_width", {31'd0, err_timeout}, 32'd0);
    check("lto_p1_busy", {31'd0, busy}, 32'd1);
    check("lto_p1_owner", {31'd0, owner}, 32'd1);
    send(1'b1, 10'h1EE, 1'b0, "lto_unlock");

    // Owner handshake in the cycle the lock timeout would fire wins.
    send(1'b0, 10'h011, 1'b1, "lsim_addr");
    repeat (15) tick();
    send(1'b0, 10'h022, 1'b1, "lsim_reload");
    check("lsim_no_err", {31'd0, err_timeout}, 32'd0);
    send(1'b0, 10'h100, 1'b0, "lsim_unlock");

    // Read timeout with no RAM response.
    send(1'b0, 10'h300, 1'b1, "rto_cmd");
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("rto_quiet%0d", i), {31'd0, err_timeout}, 32'd0);
      tick();
    end
    check("rto_err", {31'd0, err_timeout}, 32'd1);
    check("rto_idle", {31'd0, busy}, 32'd0);
    check("rto_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
    tick();
    check("rto_err_width", {31'd0, err_timeout}, 32'd0);

    // RAM answers on the 8th cycle: response wins, no error.
    send(1'b0, 10'h3FF, 1'b1, "rlast_cmd");
    repeat (7) tick();
    check("rlast_still_busy", {31'd0, busy}, 32'd1);
    ram_tx_valid = 1'b1; ram_dout = 8'hA5;
    q_rsp0.push_back(8'hA5);
    tick();
    ram_tx_valid = 1'b0;
    check("rlast_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("rlast_rsp0_data", {24'd0, rsp0_data}, 32'hA5);
    check("rlast_no_err", {31'd0, err_timeout}, 32'd0);
    check("rlast_idle", {31'd0, busy}, 32'd0);

    // Reset while waiting for read data drops the pending read.
    send(1'b1, 10'h3AA, 1'b1, "rst_cmd");
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    ram_tx_valid = 1'b1; ram_dout = 8'h77;
    tick();
    ram_tx_valid = 1'b0;
    check("midrst_late_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check("midrst_late_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);

    tick();
    tick();
    check("sb_ram_drained", q_ram.size(), 32'd0);
    check("sb_rsp0_drained", q_rsp0.size(), 32'd0);
    check("sb_rsp1_drained", q_rsp1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
